// File: rtl/ca_prng_engine.sv
// ca_prng_engine: 1D radius-1 cellular-automaton PRNG packing centre-cell bits into output words.
// Optional all-zero recovery (reload from seed register) enabled by defining CA_STUCK_DETECT_EN.
module ca_prng_engine #(
  parameter int          ARRAY_WIDTH  = 11,
  parameter int          OUT_WIDTH    = 8,
  parameter logic [7:0]  RULE_DEFAULT = 8'd30
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_seed_load,
  input  logic [ARRAY_WIDTH-1:0] i_seed,
  input  logic [7:0]             i_rule,
  input  logic                   i_boundary,
  input  logic                   i_start,
  input  logic [15:0]            i_words,
  input  logic                   i_out_ready,
  output logic                   o_out_valid,
  output logic [OUT_WIDTH-1:0]   o_out_data,
  output logic                   o_busy,
  output logic [ARRAY_WIDTH-1:0] o_state,
  output logic                   o_stuck
);
`ifdef CA_STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif
  localparam int CENTRE = ARRAY_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [ARRAY_WIDTH-1:0] grid_q, grid_d, seed_q, seed_d, nxt;
  logic [7:0]             rule_q, rule_d;
  logic                   bnd_q, bnd_d;
  logic [OUT_WIDTH-1:0]   coll_q, coll_d, coll_sh, data_q, data_d;
  logic [5:0]             bits_q, bits_d;
  logic [15:0]            words_q, words_d;
  logic                   valid_q, valid_d, stuck_q, stuck_d, zero_q, zero_d;

  // In null mode the edge cells see 0 where the wrap-around neighbour would be.
  always_comb begin
    nxt = '0;
    for (int i = 0; i < ARRAY_WIDTH; i++)
      nxt[i] = rule_q[{grid_q[(i+1)%ARRAY_WIDTH] & !(bnd_q && i == ARRAY_WIDTH-1),
                       grid_q[i],
                       grid_q[(i+ARRAY_WIDTH-1)%ARRAY_WIDTH] & !(bnd_q && i == 0)}];
  end

  assign coll_sh = (coll_q << 1) | OUT_WIDTH'(nxt[CENTRE]);

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    seed_d  = seed_q;
    rule_d  = rule_q;
    bnd_d   = bnd_q;
    coll_d  = coll_q;
    bits_d  = bits_q;
    words_d = words_q;
    data_d  = data_q;
    valid_d = valid_q;
    stuck_d = 1'b0;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (i_seed_load) begin
          grid_d = i_seed;
          seed_d = i_seed;
          rule_d = i_rule;
          bnd_d  = i_boundary;
          zero_d = 1'b0;
        end
        if (i_start && i_words != '0) begin
          words_d = i_words;
          coll_d  = '0;
          bits_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (STUCK_EN && zero_q) begin
          grid_d  = seed_q;
          stuck_d = 1'b1;
          zero_d  = 1'b0;
        end else begin
          grid_d = nxt;
          coll_d = coll_sh;
          bits_d = bits_q + 6'd1;
          zero_d = STUCK_EN && nxt == '0;
          if (bits_q == 6'(OUT_WIDTH-1)) begin
            data_d  = coll_sh;
            valid_d = 1'b1;
            bits_d  = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_out_ready) begin
          valid_d = 1'b0;
          words_d = words_q - 16'd1;
          coll_d  = '0;
          state_d = words_q == 16'd1 ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      grid_q  <= '0;
      seed_q  <= '0;
      rule_q  <= RULE_DEFAULT;
      bnd_q   <= 1'b0;
      coll_q  <= '0;
      bits_q  <= '0;
      words_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      seed_q  <= seed_d;
      rule_q  <= rule_d;
      bnd_q   <= bnd_d;
      coll_q  <= coll_d;
      bits_q  <= bits_d;
      words_q <= words_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      zero_q  <= zero_d;
    end
  end

  assign o_out_valid = valid_q;
  assign o_out_data  = data_q;
  assign o_busy      = state_q != IDLE;
  assign o_state     = grid_q;
  assign o_stuck     = stuck_q;
endmodule

// File: tb/tb_ca_prng_engine.sv
// tb_ca_prng_engine: directed checks of the CA PRNG engine with hand-computed rule-30 evolutions.
module tb_ca_prng_engine;
  logic        clk = 1'b0, rst = 1'b1, seed_load = 1'b0, boundary = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [10:0] seed = '0;
  logic [7:0]  rule = 8'd30;
  logic [15:0] words = '0;
  logic        out_valid, busy, stuck;
  logic [7:0]  out_data;
  logic [10:0] state;
  int          n_chk = 0, n_fail = 0;
  logic [10:0] gen_exp [8] = '{11'h070, 11'h0C8, 11'h1BC, 11'h322, 11'h6F7, 11'h084, 11'h1CE, 11'h339};

  always #5 clk = ~clk;

  ca_prng_engine dut (
    .i_clk(clk), .i_rst(rst), .i_seed_load(seed_load), .i_seed(seed), .i_rule(rule),
    .i_boundary(boundary), .i_start(start), .i_words(words), .i_out_ready(out_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_busy(busy), .o_state(state), .o_stuck(stuck)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_start(input logic [10:0] s, input logic [7:0] r, input logic b, input logic [15:0] w);
    seed = s; rule = r; boundary = b; words = w; seed_load = 1'b1; start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stuck", stuck, 0);
    @(negedge clk) rst = 1'b1;

    load_start(11'h020, 8'd30, 1'b0, 16'd1);
    chk("load_first_state", state, 11'h020);
    chk("run_busy", busy, 1);
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      chk($sformatf("gen%0d", g + 1), state, gen_exp[g]);
      chk($sformatf("valid_gen%0d", g + 1), out_valid, g == 7);
    end
    chk("word1_data", out_data, 8'hB9);
    accept();
    chk("acc_valid", out_valid, 0);
    chk("acc_idle", busy, 0);

    load_start(11'h020, 8'd30, 1'b0, 16'd2);
    repeat (8) @(negedge clk);
    chk("w2_first_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_data", out_data, 8'hB9);
      chk("hold_state", state, 11'h339);
      chk("hold_valid", out_valid, 1);
    end
    accept();
    chk("w2_acc_valid", out_valid, 0);
    chk("w2_acc_busy", busy, 1);
    for (int g = 1; g <= 8; g++) begin
      @(negedge clk);
      chk($sformatf("w2_second_valid_c%0d", g), out_valid, g == 8);
    end
    accept();
    chk("w2_done_idle", busy, 0);

    words = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_words_busy", busy, 0);
    @(negedge clk);
    chk("zero_words_busy2", busy, 0);

    load_start(11'h020, 8'd30, 1'b0, 16'd1);
    seed = 11'h7FF; seed_load = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("busy_load_g1", state, 11'h070);
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
    chk("busy_load_g2", state, 11'h0C8);
    repeat (6) @(negedge clk);
    chk("busy_load_data", out_data, 8'hB9);
    accept();
    chk("busy_load_idle", busy, 0);

    load_start(11'h400, 8'd30, 1'b1, 16'd1);
    chk("null_seed", state, 11'h400);
    @(negedge clk);
    chk("null_gen1", state, 11'h600);
    repeat (7) @(negedge clk);
    chk("null_hold_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_state", state, 0);
    chk("arst_stuck", stuck, 0);
    @(negedge clk) rst = 1'b1;

    load_start(11'h020, 8'd30, 1'b0, 16'd1);
    chk("post_rst_seed", state, 11'h020);
    @(negedge clk);
    chk("post_rst_gen1", state, 11'h070);
    repeat (7) @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 8'hB9);
    accept();
    chk("post_rst_idle", busy, 0);

    load_start(11'h155, 8'd0, 1'b0, 16'd1);
    chk("stk_seed", state, 11'h155);
    @(negedge clk);
    chk("stk_gen1", state, 0);
    chk("stk_gen1_pulse", stuck, 0);
    @(negedge clk);
`ifdef CA_STUCK_DETECT_EN
    chk("stk_reload", state, 11'h155);
    chk("stk_pulse", stuck, 1);
`else
    chk("stk_stay_zero", state, 0);
    chk("stk_no_pulse", stuck, 0);
`endif
    @(negedge clk);
    chk("stk_after", state, 0);
    chk("stk_pulse_end", stuck, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ca_prng_engine.md
CA_PRNG_ENGINE -- requirements
Module: ca_prng_engine

Interface
REQ-001 Parameter ARRAY_WIDTH, default 11: number of cells in the 1D grid, minimum 3.
REQ-002 Parameter OUT_WIDTH, default 8: bits per output word, range 1..32.
REQ-003 Parameter RULE_DEFAULT, default 30: Wolfram rule loaded into the rule register at reset.
REQ-004 i_clk  in  1  clock; all state updates on the rising edge.
REQ-005 i_rst  in  1  reset; asynchronous and active-low.
REQ-006 i_seed_load  in  1  loads seed, rule and boundary mode when IDLE.
REQ-007 i_seed  in  ARRAY_WIDTH  seed value for the grid.
REQ-008 i_rule  in  8  rule number, radius-1 neighbourhood.
REQ-009 i_boundary  in  1  boundary mode: 0 = periodic (wrap), 1 = null (edges see 0).
REQ-010 i_start  in  1  starts a run when IDLE.
REQ-011 i_words  in  16  number of output words to produce in the run.
REQ-012 i_out_ready  in  1  consumer accepts the output word.
REQ-013 o_out_valid  out  1  output word valid.
REQ-014 o_out_data  out  OUT_WIDTH  packed centre-cell bits.
REQ-015 o_busy  out  1  high when not IDLE.
REQ-016 o_state  out  ARRAY_WIDTH  current grid contents.
REQ-017 o_stuck  out  1  one-cycle pulse on all-zero recovery (see Configuration).

Function
REQ-018 Next value of cell i SHALL be rule[{L,C,R}], with L = cell i+1, C = cell i, R = cell i-1, and {L,C,R} read as a 3-bit index, L the MSB.
REQ-019 Edge neighbours SHALL follow the boundary mode:
- periodic: cell ARRAY_WIDTH-1 sees cell 0 as L; cell 0 sees cell ARRAY_WIDTH-1 as R.
- null: missing neighbours read 0.
REQ-020 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-021 IDLE: i_seed_load=1 latches i_seed into the grid and into the seed register, and latches i_rule and i_boundary, in one cycle.
REQ-022 IDLE: i_start=1 with i_words!=0 latches the word count, clears the collector and bit count, and enters RUN; i_start=1 with i_words=0 is ignored.
REQ-023 IDLE: if i_seed_load and i_start are high together, the load takes effect first and the run uses the new seed.
REQ-024 RUN: every cycle SHALL compute exactly one generation.
- The new centre cell (index ARRAY_WIDTH/2) shifts into the collector LSB.
- After OUT_WIDTH generations, o_out_data takes the collector value, o_out_valid goes high, and the FSM enters HOLD.
REQ-025 HOLD: the grid is frozen and o_out_data is stable while o_out_valid=1 and i_out_ready=0.
REQ-026 HOLD: on i_out_ready=1, o_out_valid clears and the word count decrements; the FSM returns to RUN if the count is non-zero, otherwise to IDLE.
REQ-027 Latency: the first word is valid OUT_WIDTH cycles after the start cycle.
REQ-028 i_seed_load and i_start SHALL be ignored while o_busy=1.
REQ-029 o_state SHALL update only on generation cycles, seed loads and stuck reloads.

Reset
REQ-030 Reset SHALL set: grid=0, seed register=0, rule=RULE_DEFAULT, boundary=periodic, FSM=IDLE, collector=0, counters=0, o_out_valid=0, o_out_data=0, o_stuck=0.
REQ-031 Reset asserted mid-run SHALL abort immediately; any pending word is discarded.

Configuration
REQ-032 Macro CA_STUCK_DETECT_EN.
- Defined: if a generation produces an all-zero grid, the grid SHALL be reloaded from the seed register in the next cycle instead of evolving, and o_stuck pulses for one cycle. The reload cycle contributes no collector bit.
- Undefined: no detection; o_stuck is tied to 0 and an all-zero grid evolves normally.

Verification
REQ-033 ARRAY_WIDTH=11, rule 30, periodic, seed 11'h020, start with i_words=1 -> o_state=11'h070 after generation 1 and 11'h0C8 after generation 2.
REQ-034 OUT_WIDTH=8, i_words=2, i_out_ready held 0 for 5 cycles after the first valid -> o_out_data and o_state stable for those 5 cycles; second word valid 8 cycles after acceptance; then IDLE.
REQ-035 i_start with i_words=0 -> o_busy stays 0; i_seed_load during RUN -> grid and seed register unchanged.
REQ-036 Null boundary, rule 30, seed 11'h400 -> generation 1 = 11'h600 (bit 10 sees L=0).
REQ-037 CA_STUCK_DETECT_EN defined, rule 0, seed 11'h155 -> all-zero grid after generation 1, o_stuck pulse, grid reloaded to 11'h155; macro undefined -> grid stays 0, o_stuck=0.
REQ-038 i_rst asserted while in HOLD -> all outputs at reset values asynchronously; after release a new run starts cleanly.
